// File: rtl/vjtag_dr_responder.sv
// ---------------------------------------------------------------------------
// vjtag_dr_responder
// User-side data-register responder behind a virtual JTAG hub instance.
// It decodes the 4-bit virtual instruction, then captures, shifts and updates
// the matching data register on tck. The host uses this path to load the
// target hash and control byte, and to read back cracker status and result.
//
// Build option:
//   VJTAG_IDCODE_EN - when defined, instruction 0x1 shifts out IDCODE.
//                     When undefined, 0x1 decodes as BYPASS and the IDCODE
//                     capture path is not built.
// ---------------------------------------------------------------------------
module vjtag_dr_responder #(
    parameter logic [31:0] IDCODE   = 32'h4D443542,
    parameter int          TARGET_W = 128,
    parameter int          RESULT_W = 64
) (
    input  logic                tck,
    input  logic                rst,
    input  logic                tdi,
    output logic                tdo,
    input  logic [3:0]          ir_in,
    output logic [3:0]          ir_out,
    input  logic                virtual_state_cdr,
    input  logic                virtual_state_sdr,
    input  logic                virtual_state_udr,
    input  logic                virtual_state_e1dr,
    input  logic                virtual_state_pdr,
    input  logic                virtual_state_e2dr,
    input  logic                virtual_state_cir,
    input  logic                virtual_state_uir,
    input  logic                found,
    input  logic                busy,
    input  logic [23:0]         attempts,
    input  logic [RESULT_W-1:0] result,
    output logic [TARGET_W-1:0] target_hash,
    output logic                target_valid,
    output logic [7:0]          ctrl,
    output logic                ctrl_strobe
);

    // Width able to hold any active length up to TARGET_W.
    localparam int LEN_W  = $clog2(TARGET_W) + 1;
    // The IDCODE and status words share the same 32-bit length.
    localparam int WORD_W = $bits(IDCODE);

    // Register selected by the current instruction.
    localparam logic [2:0] SEL_BYPASS  = 3'd0;
`ifdef VJTAG_IDCODE_EN
    localparam logic [2:0] SEL_IDCODE  = 3'd1;
`endif
    localparam logic [2:0] SEL_WR_TGT  = 3'd2;
    localparam logic [2:0] SEL_WR_CTRL = 3'd3;
    localparam logic [2:0] SEL_RD_STAT = 3'd4;
    localparam logic [2:0] SEL_RD_RES  = 3'd5;

    logic [TARGET_W-1:0] sr_r;
    logic                byp_r;
    logic                armed_r;
    logic                target_loaded_r;
    logic [TARGET_W-1:0] target_hash_r;
    logic                target_valid_r;
    logic [7:0]          ctrl_r;
    logic                ctrl_strobe_r;
    logic [3:0]          ir_out_r;

    logic [2:0]          sel_s;
    logic [LEN_W-1:0]    len_s;
    logic [TARGET_W-1:0] cap_s;
    logic [TARGET_W-1:0] sr_rsh_s;
    logic [TARGET_W-1:0] sr_shift_s;
    logic                hold_s;

    // Decode the live instruction into a register select and active length.
    always_comb begin
        sel_s = SEL_BYPASS;
        len_s = LEN_W'(1);
        case (ir_in)
            4'h0: begin
                sel_s = SEL_BYPASS;
                len_s = LEN_W'(1);
            end
`ifdef VJTAG_IDCODE_EN
            4'h1: begin
                sel_s = SEL_IDCODE;
                len_s = LEN_W'(WORD_W);
            end
`endif
            4'h2: begin
                sel_s = SEL_WR_TGT;
                len_s = LEN_W'(TARGET_W);
            end
            4'h3: begin
                sel_s = SEL_WR_CTRL;
                len_s = LEN_W'(8);
            end
            4'h4: begin
                sel_s = SEL_RD_STAT;
                len_s = LEN_W'(WORD_W);
            end
            4'h5: begin
                sel_s = SEL_RD_RES;
                len_s = LEN_W'(RESULT_W);
            end
            default: begin
                sel_s = SEL_BYPASS;
                len_s = LEN_W'(1);
            end
        endcase
    end

    // Value loaded into the shift register in Capture-DR; write registers
    // capture their committed value so the host can read it back.
    always_comb begin
        cap_s = '0;
        case (sel_s)
`ifdef VJTAG_IDCODE_EN
            SEL_IDCODE:  cap_s = TARGET_W'(IDCODE);
`endif
            SEL_WR_TGT:  cap_s = target_hash_r;
            SEL_WR_CTRL: cap_s = TARGET_W'(ctrl_r);
            SEL_RD_STAT: cap_s = TARGET_W'({found, busy, 6'b000000, attempts});
            SEL_RD_RES:  cap_s = TARGET_W'(result);
            default:     cap_s = '0;
        endcase
    end

    // Next shift value: LSB out, tdi enters at bit len-1, bits above forced 0.
    always_comb begin
        sr_rsh_s   = sr_r >> 1;
        sr_shift_s = '0;
        for (int i = 0; i < TARGET_W; i++) begin
            if (i == int'(len_s) - 1) begin
                sr_shift_s[i] = tdi;
            end else if (i < int'(len_s) - 1) begin
                sr_shift_s[i] = sr_rsh_s[i];
            end else begin
                sr_shift_s[i] = 1'b0;
            end
        end
    end

    // States in which the DR path explicitly does nothing.
    assign hold_s = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr
                  | virtual_state_cir;

    // DR state machine actions, commits, and the registered status nibble.
    // A commit only happens if a capture preceded it since the last reset,
    // update or Update-IR, so a reset mid-shift can never produce a pulse.
    always_ff @(posedge tck) begin
        if (rst) begin
            sr_r            <= '0;
            byp_r           <= 1'b0;
            armed_r         <= 1'b0;
            target_loaded_r <= 1'b0;
            target_hash_r   <= '0;
            target_valid_r  <= 1'b0;
            ctrl_r          <= 8'h00;
            ctrl_strobe_r   <= 1'b0;
            ir_out_r        <= 4'b0001;
        end else begin
            target_valid_r <= 1'b0;
            ctrl_strobe_r  <= 1'b0;
            ir_out_r       <= {found, busy, target_loaded_r, 1'b1};
            if (virtual_state_udr) begin
                armed_r <= 1'b0;
                if (armed_r && (sel_s == SEL_WR_TGT)) begin
                    target_hash_r   <= sr_r;
                    target_valid_r  <= 1'b1;
                    target_loaded_r <= 1'b1;
                end else if (armed_r && (sel_s == SEL_WR_CTRL)) begin
                    ctrl_r        <= sr_r[7:0];
                    ctrl_strobe_r <= 1'b1;
                end else begin
                    target_hash_r <= target_hash_r;
                end
            end else if (virtual_state_sdr) begin
                if (sel_s == SEL_BYPASS) begin
                    byp_r <= tdi;
                end else begin
                    sr_r <= sr_shift_s;
                end
            end else if (virtual_state_cdr) begin
                armed_r <= 1'b1;
                if (sel_s == SEL_BYPASS) begin
                    byp_r <= 1'b0;
                end else begin
                    sr_r <= cap_s;
                end
            end else if (virtual_state_uir) begin
                sr_r    <= '0;
                byp_r   <= 1'b0;
                armed_r <= 1'b0;
            end else if (hold_s) begin
                sr_r  <= sr_r;
                byp_r <= byp_r;
            end else begin
                sr_r  <= sr_r;
                byp_r <= byp_r;
            end
        end
    end

    // The hub samples tdo on the falling edge, so it is taken straight from
    // the registers.
    assign tdo          = (sel_s == SEL_BYPASS) ? byp_r : sr_r[0];
    assign ir_out       = ir_out_r;
    assign target_hash  = target_hash_r;
    assign target_valid = target_valid_r;
    assign ctrl         = ctrl_r;
    assign ctrl_strobe  = ctrl_strobe_r;

endmodule
